alu_result_narrower: RTL and testbench

- Downstream stage of fixed_point_alu. Captures the registered Q16.8 result (signed 24-bit) and its overflow flag.
- Saturates each result to Q8.8 (signed 16-bit) and buffers it in a small FIFO.
- Hands results to the consumer over a valid/ready interface.
- Keeps a sticky overflow flag and a saturation event counter for status readback.

---
 rtl/alu_result_narrower.sv | 142 ++++++++++++++
 tb/tb_alu_result_narrower.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_narrower.sv
// Saturates signed Q16.8 ALU results to Q8.8 and buffers them in a small valid/ready FIFO.
// Optional same-cycle bypass when empty is enabled by defining ALU_RES_BYPASS_EN.
module alu_result_narrower #(
    parameter int DEPTH = 4,
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       in_ovf,
    input  logic [1:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [1:0]                 out_flags,
    output logic [1:0]                 out_op,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sticky_ovf,
    input  logic                       clr_sticky,
    output logic [CNT_W-1:0]           sat_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = OUT_W + 4;
    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [OUT_W-1:0] nar_data;
    logic             nar_sat;
    logic [EW-1:0]    nar_entry;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    last_entry;
    logic [EW-1:0]    out_entry;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             empty;
    logic             push;
    logic             bypass;
    logic             wr_en;
    logic             pop;

    always_comb begin
        nar_data = in_data[OUT_W-1:0];
        nar_sat  = 1'b0;
        if ($signed(in_data) > SAT_MAX) begin
            nar_data = {1'b0, {(OUT_W-1){1'b1}}};
            nar_sat  = 1'b1;
        end else if ($signed(in_data) < SAT_MIN) begin
            nar_data = {1'b1, {(OUT_W-1){1'b0}}};
            nar_sat  = 1'b1;
        end
    end

    assign nar_entry = {nar_data, nar_sat, in_ovf, in_op};
    assign empty     = (count == '0);
    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;

`ifdef ALU_RES_BYPASS_EN
    assign bypass = empty && in_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result counts as pushed and popped at once, so it never touches storage.
    assign wr_en     = push && !bypass;
    assign pop       = !empty && out_ready;
    assign out_valid = !empty || bypass;

    // When empty the outputs fall back to the last entry that left the block.
    always_comb begin
        out_entry = last_entry;
        if (bypass) begin
            out_entry = nar_entry;
        end else if (!empty) begin
            out_entry = mem[rd_ptr];
        end
    end

    assign out_data  = out_entry[EW-1:4];
    assign out_flags = out_entry[3:2];
    assign out_op    = out_entry[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= nar_entry;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            last_entry <= '0;
        end else if (bypass) begin
            last_entry <= nar_entry;
        end else if (pop) begin
            last_entry <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wr_en && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !wr_en) begin
            count <= count - 1'b1;
        end
    end

    // Setting wins over clearing so an event in the clear cycle is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
        end else if (push && (nar_sat || in_ovf)) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (push && nar_sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_narrower.sv
// Self-checking bench for alu_result_narrower: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_alu_result_narrower;

    localparam int DEPTH = 4;
    localparam int IN_W  = 24;
    localparam int OUT_W = 16;
    localparam int CNT_W = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_ovf;
    logic [1:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [1:0]        out_flags;
    logic [1:0]        out_op;
    logic [CW-1:0]     count;
    logic              sticky_ovf;
    logic              clr_sticky;
    logic [CNT_W-1:0]  sat_cnt;

    alu_result_narrower #(
        .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ovf(in_ovf), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_op(out_op),
        .count(count), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
        .sat_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        sat;
        logic        ovf;
        logic [1:0]  op;
    } entry_t;

    entry_t m_q[$];
    entry_t m_last;
    bit     m_sticky;
    int     m_satcnt;
    int     tests;
    int     fails;

    // Reference narrowing done on plain integers.
    function automatic entry_t narrow(logic [23:0] d, logic ovf, logic [1:0] op);
        entry_t e;
        int v;
        v = $signed(d);
        e.ovf = ovf;
        e.op  = op;
        if (v > 32767) begin
            e.d = 16'h7FFF; e.sat = 1'b1;
        end else if (v < -32768) begin
            e.d = 16'h8000; e.sat = 1'b1;
        end else begin
            e.d = 16'(v); e.sat = 1'b0;
        end
        return e;
    endfunction

    function automatic bit modelBypass();
        bit b;
        b = 1'b0;
`ifdef ALU_RES_BYPASS_EN
        b = (m_q.size() == 0) && in_valid && out_ready;
`endif
        return b;
    endfunction

    task automatic modelReset();
        m_q.delete();
        m_last   = '{16'h0, 1'b0, 1'b0, 2'b00};
        m_sticky = 1'b0;
        m_satcnt = 0;
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        entry_t cur;
        bit byp;
        byp = modelBypass();
        if (byp) cur = narrow(in_data, in_ovf, in_op);
        else if (m_q.size() != 0) cur = m_q[0];
        else cur = m_last;
        checkValue("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        checkValue("out_valid", 32'(out_valid), 32'((m_q.size() != 0) || byp));
        checkValue("out_data", 32'(out_data), 32'(cur.d));
        checkValue("out_flags", 32'(out_flags), 32'({cur.sat, cur.ovf}));
        checkValue("out_op", 32'(out_op), 32'(cur.op));
        checkValue("count", 32'(count), 32'(m_q.size()));
        checkValue("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
        checkValue("sat_cnt", 32'(sat_cnt), 32'(m_satcnt));
    endtask

    task automatic driveInputs(input logic iv, input logic [23:0] id, input logic io,
                               input logic [1:0] iop, input logic ordy, input logic clr);
        in_valid   = iv;
        in_data    = id;
        in_ovf     = io;
        in_op      = iop;
        out_ready  = ordy;
        clr_sticky = clr;
    endtask

    // Commits the model with the inputs that were present at the edge, then returns at negedge.
    task automatic advance();
        entry_t e;
        bit byp, push, pop;
        e    = narrow(in_data, in_ovf, in_op);
        byp  = modelBypass();
        push = in_valid && (m_q.size() < DEPTH);
        pop  = (m_q.size() != 0) && out_ready;
        @(posedge clk);
        if (byp) begin
            m_last = e;
        end else begin
            if (pop) m_last = m_q.pop_front();
            if (push) m_q.push_back(e);
        end
        if (push && (e.sat || e.ovf)) m_sticky = 1'b1;
        else if (clr_sticky) m_sticky = 1'b0;
        if (push && e.sat && m_satcnt < 255) m_satcnt++;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic iv, input logic [23:0] id, input logic io,
                                 input logic [1:0] iop, input logic ordy, input logic clr);
        driveInputs(iv, id, io, iop, ordy, clr);
        #1;
        checkOutput();
        advance();
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        checkValue("rst_out_valid", 32'(out_valid), 32'(0));
        checkValue("rst_count", 32'(count), 32'(0));
        checkValue("rst_sticky", 32'(sticky_ovf), 32'(0));
        checkValue("rst_sat_cnt", 32'(sat_cnt), 32'(0));
        checkValue("rst_in_ready", 32'(in_ready), 32'(1));
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        iv;
        logic [23:0] id;
        logic        io;
        logic [1:0]  iop;
        logic        ordy;
        logic        clr;
        logic        e_ov;
        logic [15:0] e_d;
        logic [1:0]  e_f;
        logic [1:0]  e_op;
        int          e_cnt;
        logic        e_st;
        int          e_sc;
    } vec_t;

    vec_t vecs [11];

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        driveInputs(1'b0, 24'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        modelReset();
        @(negedge clk);
        doReset();

`ifndef ALU_RES_BYPASS_EN
        vecs[0]  = '{0, 24'h000000, 0, 2'b00, 1, 0,  0, 16'h0000, 2'b00, 2'b00, 0, 0, 0};
        vecs[1]  = '{1, 24'h000300, 0, 2'b00, 1, 0,  0, 16'h0000, 2'b00, 2'b00, 0, 0, 0};
        vecs[2]  = '{0, 24'h000000, 0, 2'b00, 1, 0,  1, 16'h0300, 2'b00, 2'b00, 1, 0, 0};
        vecs[3]  = '{1, 24'h3F0100, 0, 2'b10, 1, 0,  0, 16'h0300, 2'b00, 2'b00, 0, 0, 0};
        vecs[4]  = '{1, 24'hFF7F00, 0, 2'b00, 1, 0,  1, 16'h7FFF, 2'b10, 2'b10, 1, 1, 1};
        vecs[5]  = '{0, 24'h000000, 0, 2'b00, 1, 0,  1, 16'h8000, 2'b10, 2'b00, 1, 1, 2};
        vecs[6]  = '{0, 24'h000000, 0, 2'b00, 1, 0,  0, 16'h8000, 2'b10, 2'b00, 0, 1, 2};
        vecs[7]  = '{1, 24'h000000, 1, 2'b01, 0, 1,  0, 16'h8000, 2'b10, 2'b00, 0, 1, 2};
        vecs[8]  = '{0, 24'h000000, 0, 2'b00, 0, 1,  1, 16'h0000, 2'b01, 2'b01, 1, 1, 2};
        vecs[9]  = '{0, 24'h000000, 0, 2'b00, 1, 0,  1, 16'h0000, 2'b01, 2'b01, 1, 0, 2};
        vecs[10] = '{0, 24'h000000, 0, 2'b00, 1, 0,  0, 16'h0000, 2'b01, 2'b01, 0, 0, 2};
        for (int i = 0; i < 11; i++) begin
            driveInputs(vecs[i].iv, vecs[i].id, vecs[i].io, vecs[i].iop, vecs[i].ordy, vecs[i].clr);
            #1;
            checkOutput();
            checkValue($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            checkValue($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_d));
            checkValue($sformatf("vec%0d_out_flags", i), 32'(out_flags), 32'(vecs[i].e_f));
            checkValue($sformatf("vec%0d_out_op", i), 32'(out_op), 32'(vecs[i].e_op));
            checkValue($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            checkValue($sformatf("vec%0d_sticky", i), 32'(sticky_ovf), 32'(vecs[i].e_st));
            checkValue($sformatf("vec%0d_sat_cnt", i), 32'(sat_cnt), 32'(vecs[i].e_sc));
            advance();
        end
`else
        driveInputs(1'b1, 24'h000180, 1'b0, 2'b00, 1'b1, 1'b0);
        #1;
        checkOutput();
        checkValue("byp_out_valid", 32'(out_valid), 32'(1));
        checkValue("byp_out_data", 32'(out_data), 32'h0180);
        checkValue("byp_count", 32'(count), 32'(0));
        advance();
        checkValue("byp_count_after", 32'(count), 32'(0));
`endif

        // Fill past capacity with the consumer stalled, then drain in order.
        doReset();
        for (int i = 0; i < 5; i++) begin
            driveInputs(1'b1, 24'((i + 1) * 256), 1'b0, 2'(i), 1'b0, 1'b0);
            #1;
            checkOutput();
            checkValue("full_in_ready", 32'(in_ready), 32'(i < 4));
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            driveInputs(1'b0, 24'h0, 1'b0, 2'b00, 1'b1, 1'b0);
            #1;
            checkOutput();
            checkValue("drain_count", 32'(count), 32'(4 - i));
            if (i < 4) checkValue("drain_data", 32'(out_data), 32'((i + 1) * 256));
            advance();
        end

        // Refill to two entries, then push and pop together across the pointer wrap.
        applyStimulus(1'b1, 24'h001100, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 24'h002200, 1'b0, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            driveInputs(1'b1, 24'((i + 3) * 24'h001100), 1'b0, 2'(i), 1'b1, 1'b0);
            #1;
            checkOutput();
            checkValue("pp_count", 32'(count), 32'(2));
            advance();
        end

        // Mid-stream reset with three stored entries.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 24'h000100, 1'b1, 2'b11, 1'b0, 1'b0);
        checkValue("pre_rst_count", 32'(count), 32'(3));
        doReset();

        for (int i = 0; i < 400; i++) begin
            logic [23:0] d;
            int mode;
            mode = $urandom_range(0, 3);
            case (mode)
                0: d = 24'($urandom);
                1: d = 24'(int'($urandom_range(0, 65535)) - 32768);
                2: d = 24'(32767 + int'($urandom_range(0, 2)) - 1);
                default: d = 24'(-32768 + int'($urandom_range(0, 2)) - 1);
            endcase
            applyStimulus(1'($urandom_range(0, 1)), d, ($urandom_range(0, 7) == 0),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 99) == 0) doReset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
